// File: rtl/mc_main_control.sv
// ---------------------------------------------------------------------------
// mc_main_control
//   Main control FSM for the multi-cycle RV-subset processor. It decodes the
//   7-bit opcode, drives every datapath control signal (including the 2-bit
//   ALUOp for alu_control), stalls on memory through a ready handshake and
//   counts retired instructions.
//
// Configuration macro:
//   MC_CTRL_ADDI_EN - when defined, opcode 0010011 (ADDI) is decoded and runs
//                     through EXEC_I -> ALUWB. When undefined it is illegal.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset; forces control outputs to 0
//   opcode     in   IR[6:0], valid from DECODE onward
//   zero       in   ALU zero flag (branch decision)
//   mem_ready  in   memory finishes the current read/write this cycle
//   alu_op     out  00 add, 01 subtract, 10 decode from funct
//   alu_src_a  out  0 old PC, 1 rs1
//   alu_src_b  out  00 rs2, 01 constant 4, 10 immediate
//   pc_write   out  PC load enable
//   pc_src     out  0 ALU result, 1 ALUOut (branch target)
//   ir_write   out  instruction register load
//   iord       out  0 address from PC, 1 from ALUOut
//   mem_read   out  memory read request
//   mem_write  out  memory write request
//   reg_write  out  register file write enable
//   mem_to_reg out  write-back select, 1 MDR, 0 ALUOut
//   illegal_op out  one-cycle registered pulse on an undecodable opcode
//   state      out  current state (debug)
//   retired    out  retired-instruction counter, wraps
// ---------------------------------------------------------------------------
module mc_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [6:0] OP_ADDI = 7'b0010011;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_EXEC_I = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             retire_d;
  logic [CNT_W-1:0] retired_q;

  // Next-state, illegal-opcode detection and retire strobe.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    retire_d  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LD, OP_SD: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_EXEC_I;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        // Only LD/SD reach here; anything else means the IR changed under us.
        if (opcode == OP_LD)      state_d = S_MEMRD;
        else if (opcode == OP_SD) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end else begin
          state_d  = S_MEMWR;
        end
      end
      S_EXEC_R: state_d = S_ALUWB;
      S_ALUWB: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_BEQ: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      S_EXEC_I: state_d = S_ALUWB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire_d) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Control decode. Depends on state plus mem_ready/zero so the fetch write
  // enables and the branch PC write track the handshake in the same cycle.
  // Reset gates everything so the datapath is quiet while rst is held.
  always_comb begin
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b10;  // branch target into ALUOut
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 1'b1;
          pc_write  = zero;
        end
`ifdef MC_CTRL_ADDI_EN
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mc_main_control.sv
// ---------------------------------------------------------------------------
// tb_mc_main_control
//   Directed bench for mc_main_control. A second instance with CNT_W = 2
//   shares all inputs to exercise counter wrap.
// ---------------------------------------------------------------------------
module tb_mc_main_control;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic [1:0]  alu_op, alu_src_b;
  logic        alu_src_a, pc_write, pc_src, ir_write, iord;
  logic        mem_read, mem_write, reg_write, mem_to_reg, illegal_op;
  logic [3:0]  state;
  logic [15:0] retired;

  logic [1:0]  b_alu_op, b_alu_src_b;
  logic        b_alu_src_a, b_pc_write, b_pc_src, b_ir_write, b_iord;
  logic        b_mem_read, b_mem_write, b_reg_write, b_mem_to_reg, b_illegal_op;
  logic [3:0]  b_state;
  logic [1:0]  b_retired;

  int n_vec = 0;
  int n_bad = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  mc_main_control #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state(state),
    .retired(retired)
  );

  mc_main_control #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(b_alu_op), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .pc_write(b_pc_write), .pc_src(b_pc_src), .ir_write(b_ir_write), .iord(b_iord),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .reg_write(b_reg_write),
    .mem_to_reg(b_mem_to_reg), .illegal_op(b_illegal_op), .state(b_state),
    .retired(b_retired)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; checks are made 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
    check_vec("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
  endtask

  task automatic run_r;
    opcode = OP_R;
    repeat (4) tick;
    exp_ret++;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    tick; tick;
    check_vec("rst_state",     32'(state),      32'd0);
    check_vec("rst_retired",   32'(retired),    32'd0);
    check_vec("rst_mem_read",  32'(mem_read),   32'd0);
    check_vec("rst_alu_src_b", 32'(alu_src_b),  32'd0);
    check_vec("rst_ir_write",  32'(ir_write),   32'd0);
    check_vec("rst_pc_write",  32'(pc_write),   32'd0);
    check_vec("rst_illegal",   32'(illegal_op), 32'd0);

    rst = 1'b0; #1;
    check_vec("fetch_mem_read", 32'(mem_read),  32'd1);
    check_vec("fetch_src_b",    32'(alu_src_b), 32'd1);
    check_vec("fetch_ir_write", 32'(ir_write),  32'd1);
    check_vec("fetch_pc_write", 32'(pc_write),  32'd1);

    // R-type: 0,1,6,7,0
    opcode = OP_R;
    tick;
    check_vec("r_decode_state", 32'(state),     32'd1);
    check_vec("r_decode_src_b", 32'(alu_src_b), 32'd2);
    check_vec("r_decode_rd",    32'(mem_read),  32'd0);
    tick;
    check_vec("r_exec_state",   32'(state),     32'd6);
    check_vec("r_exec_alu_op",  32'(alu_op),    32'd2);
    check_vec("r_exec_src_a",   32'(alu_src_a), 32'd1);
    check_vec("r_exec_src_b",   32'(alu_src_b), 32'd0);
    tick;
    check_vec("r_wb_state",     32'(state),      32'd7);
    check_vec("r_wb_reg_write", 32'(reg_write),  32'd1);
    check_vec("r_wb_m2r",       32'(mem_to_reg), 32'd0);
    check_vec("r_wb_retired",   32'(retired),    32'd0);
    tick; exp_ret++;
    check_vec("r_done_state",   32'(state),   32'd0);
    check_vec("r_done_retired", 32'(retired), 32'(exp_ret));

    // Fetch wait: no IR/PC write, state holds
    mem_ready = 1'b0; #1;
    check_vec("fwait_ir_write", 32'(ir_write), 32'd0);
    check_vec("fwait_pc_write", 32'(pc_write), 32'd0);
    tick;
    check_vec("fwait_state", 32'(state), 32'd0);
    mem_ready = 1'b1;

    // LD with 3 wait cycles in MEMRD: 0,1,2,3,3,3,3,4 -> 8 cycles
    opcode = OP_LD;
    tick;
    tick;
    check_vec("ld_adr_state", 32'(state),     32'd2);
    check_vec("ld_adr_src_a", 32'(alu_src_a), 32'd1);
    check_vec("ld_adr_src_b", 32'(alu_src_b), 32'd2);
    mem_ready = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      check_vec($sformatf("ld_rd%0d_state", i), 32'(state),     32'd3);
      check_vec($sformatf("ld_rd%0d_rd", i),    32'(mem_read),  32'd1);
      check_vec($sformatf("ld_rd%0d_iord", i),  32'(iord),      32'd1);
      check_vec($sformatf("ld_rd%0d_wr", i),    32'(mem_write), 32'd0);
      tick;
    end
    check_vec("ld_wb_state",     32'(state),      32'd4);
    check_vec("ld_wb_reg_write", 32'(reg_write),  32'd1);
    check_vec("ld_wb_m2r",       32'(mem_to_reg), 32'd1);
    tick; exp_ret++;
    check_vec("ld_done_state",   32'(state),   32'd0);
    check_vec("ld_done_retired", 32'(retired), 32'(exp_ret));

    // BEQ taken and not taken: 0,1,8,0
    for (int z = 1; z >= 0; z--) begin
      opcode = OP_BEQ; zero = z[0];
      tick;
      tick;
      check_vec($sformatf("beq%0d_state", z),    32'(state),    32'd8);
      check_vec($sformatf("beq%0d_pc_write", z), 32'(pc_write), 32'(z));
      check_vec($sformatf("beq%0d_pc_src", z),   32'(pc_src),   32'd1);
      check_vec($sformatf("beq%0d_alu_op", z),   32'(alu_op),   32'd1);
      tick; exp_ret++;
      check_vec($sformatf("beq%0d_done_state", z), 32'(state),   32'd0);
      check_vec($sformatf("beq%0d_retired", z),    32'(retired), 32'(exp_ret));
    end
    zero = 1'b0;

    // Illegal opcode: pulse one cycle, no retire, no writes
    opcode = OP_BAD;
    tick;
    check_vec("ill_dec_state",   32'(state),      32'd1);
    check_vec("ill_dec_pulse",   32'(illegal_op), 32'd0);
    tick;
    check_vec("ill_state",       32'(state),      32'd0);
    check_vec("ill_pulse",       32'(illegal_op), 32'd1);
    check_vec("ill_reg_write",   32'(reg_write),  32'd0);
    check_vec("ill_mem_write",   32'(mem_write),  32'd0);
    check_vec("ill_retired",     32'(retired),    32'(exp_ret));
    mem_ready = 1'b0;
    tick;
    check_vec("ill_pulse_end",   32'(illegal_op), 32'd0);
    check_vec("ill_hold_state",  32'(state),      32'd0);
    mem_ready = 1'b1;

    // ADDI: legal only when the feature is built in
    opcode = OP_ADDI;
    tick;
    tick;
`ifdef MC_CTRL_ADDI_EN
    check_vec("addi_exec_state", 32'(state),     32'd9);
    check_vec("addi_exec_src_a", 32'(alu_src_a), 32'd1);
    check_vec("addi_exec_src_b", 32'(alu_src_b), 32'd2);
    check_vec("addi_exec_alu_op", 32'(alu_op),   32'd0);
    tick;
    check_vec("addi_wb_state",   32'(state),     32'd7);
    check_vec("addi_wb_reg",     32'(reg_write), 32'd1);
    tick; exp_ret++;
    check_vec("addi_done_state", 32'(state),     32'd0);
    check_vec("addi_retired",    32'(retired),   32'(exp_ret));
`else
    check_vec("addi_ill_state",  32'(state),      32'd0);
    check_vec("addi_ill_pulse",  32'(illegal_op), 32'd1);
    check_vec("addi_retired",    32'(retired),    32'(exp_ret));
    mem_ready = 1'b0;
    tick;
    mem_ready = 1'b1;
`endif

    // SD with ready: 0,1,2,5,0 -> 4 cycles
    opcode = OP_SD;
    tick;
    tick;
    tick;
    check_vec("sd_wr_state", 32'(state),     32'd5);
    check_vec("sd_wr_wr",    32'(mem_write), 32'd1);
    check_vec("sd_wr_iord",  32'(iord),      32'd1);
    check_vec("sd_wr_rd",    32'(mem_read),  32'd0);
    tick; exp_ret++;
    check_vec("sd_done_state", 32'(state),   32'd0);
    check_vec("sd_retired",    32'(retired), 32'(exp_ret));

    // SD stalled in MEMWR, then reset mid-instruction
    tick;
    tick;
    mem_ready = 1'b0;
    tick;
    tick;
    check_vec("sdw_state",   32'(state),     32'd5);
    check_vec("sdw_wr",      32'(mem_write), 32'd1);
    check_vec("sdw_retired", 32'(retired),   32'(exp_ret));
    rst = 1'b1; #1;
    check_vec("mrst_wr",   32'(mem_write), 32'd0);
    check_vec("mrst_iord", 32'(iord),      32'd0);
    tick;
    check_vec("mrst_state",   32'(state),   32'd0);
    check_vec("mrst_retired", 32'(retired), 32'd0);
    exp_ret = 0;
    rst = 1'b0; mem_ready = 1'b1;

    // Five R-types: 16-bit counter reads 5, 2-bit counter wraps to 1
    repeat (5) run_r;
    check_vec("wrap_retired16", 32'(retired),   32'(exp_ret));
    check_vec("wrap_retired2",  32'(b_retired), 32'd1);
    check_vec("wrap_state",     32'(state),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Main control FSM of the multi-cycle (sequential) RV-subset processor.
- Decodes the 7-bit opcode and sequences every datapath control signal, including the 2-bit ALUOp that feeds alu_control.
- Handles memory wait states with a ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of the retired-instruction counter (wraps)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  7  instruction[6:0] from the IR; valid from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current read/write this cycle
alu_op  output  2  00 = add, 01 = subtract (branch), 10 = decode from funct
alu_src_a  output  1  0 = old PC, 1 = rs1 register
alu_src_b  output  2  00 = rs2, 01 = constant 4, 10 = immediate
pc_write  output  1  PC load enable
pc_src  output  1  0 = ALU result, 1 = ALUOut register (branch target)
ir_write  output  1  instruction register load
iord  output  1  0 = memory address from PC, 1 = from ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register file write enable
mem_to_reg  output  1  write-back select: 1 = MDR, 0 = ALUOut
illegal_op  output  1  one-cycle registered pulse on an undecodable opcode
state  output  4  current state, for debug
retired  output  CNT_W  count of completed instructions

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on rst.
- While rst is high at a clock edge: state <= FETCH (0), retired <= 0, illegal_op <= 0.
- While rst is high, all control outputs are combinationally forced to 0.
- Reset mid-instruction abandons the instruction. The next non-reset cycle is FETCH.
- Opcodes: R = 0110011, LD = 0000011, SD = 0100011, BEQ = 1100011.
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC_R = 6, ALUWB = 7, BEQ = 8, EXEC_I = 9. Any unused state goes to FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, a = 0, b = 01, alu_op = 00; ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready = 0, otherwise goes to DECODE.
- DECODE:
  - Outputs: a = 0, b = 10, alu_op = 00 (branch target computed into ALUOut).
  - Next: LD/SD -> MEMADR; R -> EXEC_R; BEQ -> BEQ.
  - Any other opcode -> FETCH, and illegal_op = 1 in the following cycle only. retired does not increment.
- MEMADR: a = 1, b = 10, alu_op = 00. LD -> MEMRD, SD -> MEMWR.
- MEMRD: mem_read = 1, iord = 1. Waits while mem_ready = 0, then -> MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1. -> FETCH.
- MEMWR: mem_write = 1, iord = 1. Waits while mem_ready = 0, then -> FETCH.
- EXEC_R: a = 1, b = 00, alu_op = 10. -> ALUWB.
- ALUWB: reg_write = 1, mem_to_reg = 0. -> FETCH.
- BEQ: a = 1, b = 00, alu_op = 01, pc_src = 1, pc_write = zero. -> FETCH.
- Latency with mem_ready held at 1 (cycles from FETCH entry to the next FETCH): R = 4, LD = 5, SD = 4, BEQ = 3. Each wait cycle adds 1.
- retired:
  - Increments by 1 on the edge leaving MEMWB, ALUWB, BEQ, or MEMWR (MEMWR only when mem_ready = 1).
  - Wraps from 2^CNT_W - 1 to 0.
- mem_read and mem_write are never both 1.
- Memory requests hold steady through wait cycles.

Optional Feature:
- Macro: MC_CTRL_ADDI_EN
- Defined:
  - opcode 0010011 (ADDI) in DECODE -> EXEC_I.
  - EXEC_I: a = 1, b = 10, alu_op = 00. -> ALUWB.
  - ADDI latency is 4 cycles.
- Undefined: 0010011 is illegal (illegal_op pulse, return to FETCH), and state 9 is unreachable.

Test Plan:
- Reset: rst = 1 for 2 cycles -> all outputs 0, state = 0, retired = 0. First cycle after release: mem_read = 1, alu_src_b = 01.
- R-type, opcode 0110011, mem_ready = 1:
  - Visits states 0,1,6,7,0.
  - alu_op = 10 in EXEC_R; reg_write = 1 with mem_to_reg = 0 in ALUWB.
  - retired 0 -> 1.
- LD with mem_ready low for 3 cycles in MEMRD:
  - Stays in state 3 for 4 cycles, with mem_read = 1 and iord = 1 throughout.
  - Then MEMWB with reg_write = 1 and mem_to_reg = 1.
  - 8 cycles total.
- BEQ:
  - zero = 1 -> pc_write = 1, pc_src = 1, alu_op = 01 in state 8.
  - zero = 0 -> pc_write = 0.
  - Both cases: 3 cycles, retired increments.
- Illegal opcode 1111111:
  - DECODE -> FETCH; illegal_op high exactly 1 cycle; retired unchanged; no reg_write or mem_write at any time.
  - With MC_CTRL_ADDI_EN, opcode 0010011 follows 0,1,9,7,0.
- Mid-instruction reset and counter wrap:
  - rst asserted in MEMWR -> next state 0, mem_write = 0, retired = 0.
  - With CNT_W = 2, 5 R-type instructions -> retired = 1.
